// File: rtl/incr_decr_counter.sv
// rtl/incr_decr_counter.sv - saturating up/down counter with registered error pulse
module incr_decr_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned MIN_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [1:0]       in,
    output logic             incr_decr_error,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       err_code
);

    localparam logic [1:0] CMD_DECR  = 2'b00;
    localparam logic [1:0] CMD_INCR  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

    // Bounds are held one bit wider than the counter so MAX_VAL = 2**WIDTH-1 compares exactly.
    localparam logic [WIDTH:0]   LP_MAX     = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   LP_MIN     = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH-1:0] LP_MIN_CNT = WIDTH'(MIN_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH-1:0] w_next_count;
    logic             w_err;
    logic [1:0]       w_err_code;

    assign w_count_ext = {1'b0, r_count};

    always_comb begin
        w_next_count = r_count;
        w_err        = 1'b0;
        w_err_code   = r_err_code;
        if (valid) begin
            case (in)
                CMD_INCR: begin
                    if (w_count_ext >= LP_MAX) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_OVERFLOW;
                    end else begin
                        w_next_count = r_count + WIDTH'(1);
                    end
                end
                CMD_DECR: begin
                    if (w_count_ext <= LP_MIN) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_UNDERFLOW;
                    end else begin
                        w_next_count = r_count - WIDTH'(1);
                    end
                end
                CMD_CLEAR: begin
                    w_next_count = LP_MIN_CNT;
                end
                default: begin
                    w_err      = 1'b1;
                    w_err_code = ERR_ILLEGAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= LP_MIN_CNT;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_count    <= w_next_count;
            r_err      <= w_err;
            r_err_code <= w_err_code;
        end
    end

    assign count           = r_count;
    assign incr_decr_error = r_err;
    assign err_code        = r_err_code;

endmodule

// File: tb/tb_incr_decr_counter.sv
// tb/tb_incr_decr_counter.sv - scoreboard bench for incr_decr_counter
module tb_incr_decr_counter;

    localparam int WIDTH = 8;
    localparam int MAXV  = 255;
    localparam int MINV  = 0;

    logic             clk;
    logic             rst;
    logic             valid;
    logic [1:0]       in;
    logic             incr_decr_error;
    logic [WIDTH-1:0] count;
    logic [1:0]       err_code;

    typedef struct {
        int         cnt;
        logic       err;
        logic [1:0] code;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_count  = MINV;
    logic [1:0] m_code = 2'b00;

    incr_decr_counter #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .valid(valid),
        .in(in),
        .incr_decr_error(incr_decr_error),
        .count(count),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Called at a falling edge: drive, predict, let one rising edge sample, compare at the next falling edge.
    task automatic step(input logic v, input logic [1:0] cmd, input string tag);
        exp_t e;
        logic err;
        valid = v;
        in    = cmd;
        err   = 1'b0;
        if (v) begin
            if (cmd == 2'b01) begin
                if (m_count == MAXV) begin err = 1'b1; m_code = 2'b01; end
                else m_count = m_count + 1;
            end else if (cmd == 2'b00) begin
                if (m_count == MINV) begin err = 1'b1; m_code = 2'b10; end
                else m_count = m_count - 1;
            end else if (cmd == 2'b10) begin
                m_count = MINV;
            end else begin
                err = 1'b1; m_code = 2'b11;
            end
        end
        e.cnt = m_count; e.err = err; e.code = m_code;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check({tag, "_count"}, 32'(count), 32'(e.cnt));
            check({tag, "_err"}, 32'(incr_decr_error), 32'(e.err));
            check({tag, "_code"}, 32'(err_code), 32'(e.code));
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        valid = 1'b0;
        in    = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b1;
        m_count = MINV;
        m_code  = 2'b00;
    endtask

    initial begin
        rst   = 1'b0;
        valid = 1'b1;
        in    = 2'b01;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_count", 32'(count), 32'd0);
            check("rst_err", 32'(incr_decr_error), 32'd0);
            check("rst_code", 32'(err_code), 32'd0);
        end
        rst = 1'b1;
        step(1'b1, 2'b01, "first_incr");

        do_reset();
        for (int i = 0; i < 255; i++) step(1'b1, 2'b01, "incr_run");
        check("at_max", 32'(count), 32'd255);
        step(1'b1, 2'b01, "overflow");
        step(1'b1, 2'b01, "overflow_again");
        step(1'b0, 2'b01, "overflow_end");
        step(1'b1, 2'b00, "decr_from_max");

        do_reset();
        step(1'b1, 2'b00, "underflow");
        step(1'b1, 2'b01, "uf_incr");
        step(1'b1, 2'b00, "uf_decr");
        step(1'b1, 2'b10, "clear_at_min");

        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, "pre_gate");
        for (int i = 0; i < 10; i++) begin
            logic [1:0] c;
            c = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b01 : 2'b11);
            step(1'b0, c, "gate");
        end

        do_reset();
        for (int i = 0; i < 37; i++) step(1'b1, 2'b01, "to37");
        step(1'b1, 2'b11, "reserved");
        step(1'b1, 2'b10, "clear");
        step(1'b1, 2'b10, "clear_again");

        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 2'b01, "to12");
        step(1'b1, 2'b11, "pre_async_err");
        valid = 1'b1;
        in    = 2'b01;
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_err", 32'(incr_decr_error), 32'd0);
        check("async_code", 32'(err_code), 32'd0);
        @(negedge clk);
        check("async_hold", 32'(count), 32'd0);
        rst     = 1'b1;
        m_count = MINV;
        m_code  = 2'b00;
        step(1'b1, 2'b01, "post_async");
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, "burst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
